// File: rtl/clock_divider_prog.sv
// Programmable clock divider with period-boundary reload, rise/fall strobes and enable/stop; outputs registered (1-cycle latency).
// Optional fixed-length burst mode (burst_len_in/burst_done_out) is built only when CLKDIV_BURST_EN is defined.
module clock_divider_prog #(
    parameter int WIDTH        = 28,
    parameter int DEFAULT_DIV  = 50000000,
    parameter int DEFAULT_HIGH = 25000000
) (
    input  logic             clock_in,
    input  logic             reset_in,
    input  logic             enable_in,
    input  logic [WIDTH-1:0] div_in,
    input  logic [WIDTH-1:0] high_in,
    input  logic             load_in,
`ifdef CLKDIV_BURST_EN
    input  logic [15:0]      burst_len_in,
    output logic             burst_done_out,
`endif
    output logic             load_ack_out,
    output logic             clock_out,
    output logic             rise_tick_out,
    output logic             fall_tick_out,
    output logic             running_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    // Period is forced to at least 2 and high time into 1..period-1 so the output always toggles.
    function automatic logic [2*WIDTH-1:0] clamp(input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] h);
        logic [WIDTH-1:0] de;
        logic [WIDTH-1:0] he;
        de = (d < WIDTH'(2)) ? WIDTH'(2) : d;
        he = (h == '0) ? WIDTH'(1) : h;
        if (he > de - WIDTH'(1)) begin
            he = de - WIDTH'(1);
        end
        return {de, he};
    endfunction

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] high_q, high_d;
    logic [WIDTH-1:0] pdiv_q, pdiv_d;
    logic [WIDTH-1:0] phigh_q, phigh_d;
    logic             pend_q, pend_d;
    logic             ack_q, ack_d;
    logic             clk_q, clk_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             run_q, run_d;

    logic [WIDTH-1:0] in_div, in_high;
    logic [WIDTH-1:0] def_div, def_high;
    logic [WIDTH-1:0] low_len;
    logic             wrap;
    logic             start_ok;
    logic             burst_last;

    assign {in_div, in_high}   = clamp(div_in, high_in);
    assign {def_div, def_high} = clamp(WIDTH'(DEFAULT_DIV), WIDTH'(DEFAULT_HIGH));
    assign wrap                = (cnt_q == div_q - WIDTH'(1));

`ifdef CLKDIV_BURST_EN
    logic [15:0] blen_q, blen_d;
    logic [15:0] bcnt_q, bcnt_d;
    logic        lock_q, lock_d;
    logic        done_q, done_d;

    assign start_ok   = !lock_q;
    assign burst_last = (blen_q != 16'd0) && (bcnt_q + 16'd1 == blen_q);

    always_comb begin
        blen_d = blen_q;
        bcnt_d = bcnt_q;
        lock_d = lock_q;
        done_d = 1'b0;
        if (state_q == IDLE) begin
            if (!enable_in) begin
                lock_d = 1'b0;
            end
            if (enable_in && !lock_q) begin
                blen_d = burst_len_in;
                bcnt_d = '0;
            end
        end else if (wrap) begin
            bcnt_d = bcnt_q + 16'd1;
            if (burst_last) begin
                done_d = 1'b1;
                lock_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            blen_q <= '0;
            bcnt_q <= '0;
            lock_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            blen_q <= blen_d;
            bcnt_q <= bcnt_d;
            lock_q <= lock_d;
            done_q <= done_d;
        end
    end

    assign burst_done_out = done_q;
`else
    assign start_ok   = 1'b1;
    assign burst_last = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        high_d  = high_q;
        pdiv_d  = pdiv_q;
        phigh_d = phigh_q;
        pend_d  = pend_q;
        ack_d   = 1'b0;
        fall_d  = 1'b0;

        if (load_in) begin
            pdiv_d  = in_div;
            phigh_d = in_high;
            pend_d  = 1'b1;
        end

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                // Nothing is running, so a fresh load bypasses the pending stage.
                if (load_in) begin
                    div_d  = in_div;
                    high_d = in_high;
                    ack_d  = 1'b1;
                    pend_d = 1'b0;
                end else if (pend_q) begin
                    div_d  = pdiv_q;
                    high_d = phigh_q;
                    ack_d  = 1'b1;
                    pend_d = 1'b0;
                end
                if (enable_in && start_ok) begin
                    state_d = RUN;
                end
            end
            RUN, STOP: begin
                if (wrap) begin
                    cnt_d  = '0;
                    fall_d = 1'b1;
                    // The wrap consumes the older pending value; a load in this same cycle stays pending.
                    if (pend_q) begin
                        div_d  = pdiv_q;
                        high_d = phigh_q;
                        ack_d  = 1'b1;
                        pend_d = load_in;
                    end
                    state_d = (enable_in && !burst_last) ? RUN : IDLE;
                end else begin
                    cnt_d   = cnt_q + WIDTH'(1);
                    state_d = enable_in ? RUN : STOP;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        low_len = div_d - high_d;
        run_d   = (state_d != IDLE);
        clk_d   = run_d && (cnt_d >= low_len);
        rise_d  = run_d && (cnt_d == low_len);
    end

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            div_q   <= def_div;
            high_q  <= def_high;
            pdiv_q  <= def_div;
            phigh_q <= def_high;
            pend_q  <= 1'b0;
            ack_q   <= 1'b0;
            clk_q   <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            high_q  <= high_d;
            pdiv_q  <= pdiv_d;
            phigh_q <= phigh_d;
            pend_q  <= pend_d;
            ack_q   <= ack_d;
            clk_q   <= clk_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            run_q   <= run_d;
        end
    end

    assign load_ack_out  = ack_q;
    assign clock_out     = clk_q;
    assign rise_tick_out = rise_q;
    assign fall_tick_out = fall_q;
    assign running_out   = run_q;

endmodule
